// File: rtl/sb_hfosc.sv
// -----------------------------------------------------------------------------
// sb_hfosc -- cycle-accurate model of the iCE40 high-frequency oscillator.
//
// The raw oscillator core is stood in for by the reference clock `clk`. The
// block models the power-up warm-up delay, the selectable post-divider and a
// glitch-free output enable. A `ready` flag is exported for benches and for
// clock-domain logic that must wait for a stable clock.
//
// Parameters
//   CLKHF_DIV  post-divider select: 00 = clk/1, 01 = clk/2, 10 = clk/4,
//              11 = clk/8
//   PU_CYCLES  clk rising edges of warm-up after CLKHFPU asserts (1..65535)
//
// Ports
//   clk      in   reference clock (raw oscillator core)
//   rst      in   asynchronous, active-high reset
//   CLKHFPU  in   power-up request, 1 = oscillator powered
//   CLKHFEN  in   output enable, effective only once ready
//   CLKHF    out  divided, gated oscillator clock
//   ready    out  warm-up complete and CLKHFPU still high
// -----------------------------------------------------------------------------
module sb_hfosc #(
  parameter logic [1:0]  CLKHF_DIV = 2'b00,
  parameter int unsigned PU_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic CLKHFPU,
  input  logic CLKHFEN,
  output logic CLKHF,
  output logic ready
);

  localparam logic [15:0] PU_MAX = 16'(PU_CYCLES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0] pu_cnt_q, pu_cnt_d;
  logic        ready_q,  ready_d;
  logic [2:0]  div_q,    div_d;
  logic        en_q;
  logic        gate_q;
  logic        src;

  // ---------------------------------------------------------------------------
  // Warm-up counter: counts rising edges with CLKHFPU sampled high, saturating
  // at PU_MAX. Any sampled low restarts the whole warm-up.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the if/else can leave it unassigned and
    // infer a latch.
    pu_cnt_d = pu_cnt_q;
    ready_d  = ready_q;
    if (!CLKHFPU) begin
      pu_cnt_d = '0;
      ready_d  = 1'b0;
    end else if (pu_cnt_q != PU_MAX) begin
      pu_cnt_d = pu_cnt_q + 16'd1;
      // Ready on the very edge at which the count reaches PU_MAX.
      ready_d  = (pu_cnt_q == PU_MAX - 16'd1);
    end else begin
      ready_d  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider: free-runs only while ready, held at zero otherwise so that every
  // restart begins from the same phase (src low).
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d = ready_q ? div_q + 3'd1 : 3'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pu_cnt_q <= '0;
      ready_q  <= 1'b0;
      div_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      pu_cnt_q <= pu_cnt_d;
      ready_q  <= ready_d;
      div_q    <= div_d;
      en_q     <= CLKHFEN;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider tap. With no division the raw reference is passed straight on.
  // ---------------------------------------------------------------------------
  always_comb begin
    src = clk;
    unique case (CLKHF_DIV)
      2'b00:   src = clk;
      2'b01:   src = div_q[0];
      2'b10:   src = div_q[1];
      default: src = div_q[2];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Glitch-free gate: the enable is re-evaluated only on a falling clk edge
  // while src is low, so an open gate can never chop a high phase and a
  // closed gate can only open ahead of a complete high phase. For the /1
  // case src is clk itself and this degenerates to a negedge-latched enable.
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      gate_q <= 1'b0;
    end else if (!src) begin
      gate_q <= en_q & ready_q;
    end
  end

  // Reset clears gate_q asynchronously, which forces CLKHF low at once.
  assign CLKHF = src & gate_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_sb_hfosc.sv
// -----------------------------------------------------------------------------
// tb_sb_hfosc -- self-checking bench for sb_hfosc.
//
// Four instances, one per post-divider setting, share clock, reset and the
// power-up request; each has its own enable. Expected CLKHF/ready values are
// derived from closed-form timing (edge number since warm-up completion),
// pushed to a scoreboard queue before each half cycle, and popped against the
// sampled outputs two time units after each clock edge.
// -----------------------------------------------------------------------------
module tb_sb_hfosc;

  logic       clk = 1'b0;
  logic       rst;
  logic       pu;
  logic [3:0] en;
  logic [3:0] clkhf;
  logic [3:0] rdy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sb_hfosc #(
      .CLKHF_DIV (2'(g)),
      .PU_CYCLES (16)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .CLKHFPU (pu),
      .CLKHFEN (en[g]),
      .CLKHF   (clkhf[g]),
      .ready   (rdy[g])
    );
  end

  typedef struct {
    string tag;
    logic  exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass   = 0;
  int   n_checks = 0;

  task automatic push(input string tag, input logic v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %b, no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  // Edge numbering: edge 1 is the first rising edge with CLKHFPU = 1.
  // Warm-up completes at edge 16. CLKHFPU is low for edge 73 only, so the
  // second warm-up completes at edge 73 + 16 = 89.
  function automatic logic exp_rdy(input int n);
    return (n >= 16 && n < 73) || (n >= 89);
  endfunction

  function automatic logic exp_clk(input int d, input int n, input bit hi);
    int base;
    // Edge 73: ready has just cleared. /1 still has its gate open for this
    // high half; /2 is mid high phase (divider value 57, bit0 = 1) and
    // completes it; /4 and /8 are in a low phase.
    if (n == 73) return (d == 0) ? logic'(hi) : logic'(d == 1);
    // /8 instance: enable dropped after edge 44 (first high cycle), so the
    // phase 44..47 completes, then stays low; re-enabled after edge 60 the
    // next full high phase is 68..71.
    if (d == 3 && n >= 48 && n <= 67) return 1'b0;
    base = (n < 73) ? 16 : 89;
    if (n < base) return 1'b0;
    // /1: gate opens on the falling edge after warm-up, clk high halves only.
    if (d == 0) return logic'(hi && n > base);
    // Divider value at edge n is n - base; src is bit d-1 of it.
    return logic'(((n - base) >> (d - 1)) & 1);
  endfunction

  task automatic half(input int n, input bit hi);
    push($sformatf("ready_d1@%0d", n), exp_rdy(n));
    for (int d = 0; d < 4; d++)
      push($sformatf("clkhf_div%0d@%0d%s", d, n, hi ? "h" : "l"), exp_clk(d, n, hi));
    if (hi) @(posedge clk);
    else    @(negedge clk);
    #2;
    pop_check(rdy[1]);
    for (int d = 0; d < 4; d++) pop_check(clkhf[d]);
  endtask

  task automatic check_all_low(input string tag);
    for (int d = 0; d < 4; d++) begin
      push($sformatf("%s_ready_div%0d", tag, d), 1'b0);
      push($sformatf("%s_clkhf_div%0d", tag, d), 1'b0);
    end
    for (int d = 0; d < 4; d++) begin
      pop_check(rdy[d]);
      pop_check(clkhf[d]);
    end
  endtask

  initial begin
    rst = 1'b1;
    pu  = 1'b0;
    en  = 4'h0;
    #1;
    check_all_low("por");

    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    pu  = 1'b1;
    en  = 4'hF;   // enable before ready: no output until warm-up completes

    for (int n = 1; n <= 99; n++) begin
      half(n, 1'b1);
      half(n, 1'b0);
      if (n == 44) en[3] = 1'b0;
      if (n == 60) en[3] = 1'b1;
      if (n == 72) pu    = 1'b0;
      if (n == 73) pu    = 1'b1;
    end

    // Reset asserted mid high phase: outputs must drop with no clk edge.
    half(100, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_all_low("async_rst");

    pu = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #2;
      check_all_low($sformatf("post_rst%0dh", k));
      @(negedge clk);
      #2;
      check_all_low($sformatf("post_rst%0dl", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
